// File: rtl/pipe_mux_tree_pkg.sv
// rtl/pipe_mux_tree_pkg.sv - shared limits and level sizing for the pipelined mux tree
package pipe_mux_tree_pkg;

   localparam int SEL_BITS_MAX = 8;
   localparam int DATA_W_MAX   = 64;

   // Number of words entering level `level` of a tree with `selBits` levels.
   function automatic int levelWords(input int selBits, input int level);
      return 1 << (selBits - level);
   endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// rtl/mux_tree_stage.sv - one tree level: pairwise 2:1 select on the level's LSB select bit, then register
module mux_tree_stage #(
   parameter int WORDS_IN = 2,
   parameter int DATA_W   = 8,
   parameter int SEL_REM  = 1,
   localparam int WORDS_OUT = WORDS_IN / 2,
   localparam int OUT_SEL_W = (SEL_REM > 1) ? SEL_REM - 1 : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          advance,
   input  logic [WORDS_IN*DATA_W-1:0]    inData,
   input  logic [SEL_REM-1:0]            inSel,
   input  logic                          inValid,
   output logic [WORDS_OUT*DATA_W-1:0]   outData,
   output logic [OUT_SEL_W-1:0]          outSel,
   output logic                          outValid
);

   logic [WORDS_OUT*DATA_W-1:0] picked;

   always_comb begin
      picked = '0;
      for (int k = 0; k < WORDS_OUT; k++) begin
         picked[k*DATA_W +: DATA_W] = inSel[0] ? inData[(2*k+1)*DATA_W +: DATA_W]
                                               : inData[(2*k)*DATA_W +: DATA_W];
      end
   end

   // Data loads regardless of inValid; only the valid bit carries meaning.
   always_ff @(posedge clk) begin
      if (rst) begin
         outData  <= '0;
         outValid <= 1'b0;
      end else if (advance) begin
         outData  <= picked;
         outValid <= inValid;
      end
   end

   generate
      if (SEL_REM > 1) begin : g_sel
         always_ff @(posedge clk) begin
            if (rst) begin
               outSel <= '0;
            end else if (advance) begin
               outSel <= inSel[SEL_REM-1:1];
            end
         end
      end else begin : g_noSel
         assign outSel = '0;
      end
   endgenerate

endmodule

// File: rtl/pipe_mux_tree.sv
// rtl/pipe_mux_tree.sv - SEL_BITS-level registered binary mux tree with a global stall-all handshake
module pipe_mux_tree
   import pipe_mux_tree_pkg::*;
#(
   parameter int SEL_BITS = 3,
   parameter int DATA_W   = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_W*(2**SEL_BITS)-1:0] in_data,
   input  logic [SEL_BITS-1:0]             in_sel,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [DATA_W-1:0]               out_data,
   output logic                            out_valid,
   input  logic                            out_ready
);

   localparam int NUM_IN      = 2**SEL_BITS;
   localparam int DATA_FLAT_W = DATA_W * (2*NUM_IN - 1);
   localparam int SEL_FLAT_W  = SEL_BITS * (SEL_BITS + 1) / 2;

   generate
      if (SEL_BITS < 1 || SEL_BITS > SEL_BITS_MAX) begin : g_badSelBits
         $error("pipe_mux_tree: SEL_BITS out of range");
      end
      if (DATA_W < 1 || DATA_W > DATA_W_MAX) begin : g_badDataW
         $error("pipe_mux_tree: DATA_W out of range");
      end
   endgenerate

   // All levels packed back to back: level i starts where level i-1's words end.
   logic [DATA_FLAT_W-1:0] dataFlat;
   logic [SEL_FLAT_W-1:0]  selFlat;
   logic [SEL_BITS:0]      validChain;
   logic                   advance;
   logic                   unusedLastSel;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   assign dataFlat[NUM_IN*DATA_W-1:0] = in_data;
   assign selFlat[SEL_BITS-1:0]       = in_sel;
   assign validChain[0]               = in_valid;

   generate
      for (genvar i = 0; i < SEL_BITS; i++) begin : g_level
         localparam int WORDS_IN   = levelWords(SEL_BITS, i);
         localparam int D_OFF      = DATA_W * (2*NUM_IN - 2*WORDS_IN);
         localparam int D_OFF_NEXT = D_OFF + WORDS_IN*DATA_W;
         localparam int SEL_REM    = SEL_BITS - i;
         localparam int S_OFF      = i*SEL_BITS - (i*(i-1))/2;
         localparam int OUT_SEL_W  = (SEL_REM > 1) ? SEL_REM - 1 : 1;

         logic [OUT_SEL_W-1:0] nextSel;

         mux_tree_stage #(
            .WORDS_IN (WORDS_IN),
            .DATA_W   (DATA_W),
            .SEL_REM  (SEL_REM)
         ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance),
            .inData   (dataFlat[D_OFF +: WORDS_IN*DATA_W]),
            .inSel    (selFlat[S_OFF +: SEL_REM]),
            .inValid  (validChain[i]),
            .outData  (dataFlat[D_OFF_NEXT +: (WORDS_IN/2)*DATA_W]),
            .outSel   (nextSel),
            .outValid (validChain[i+1])
         );

         if (SEL_REM > 1) begin : g_fwd
            assign selFlat[S_OFF+SEL_REM +: SEL_REM-1] = nextSel;
         end else begin : g_last
            assign unusedLastSel = nextSel[0];
         end
      end
   endgenerate

   assign out_data  = dataFlat[DATA_FLAT_W-1 -: DATA_W];
   assign out_valid = validChain[SEL_BITS];

endmodule
